wb_master_arb: RTL

WB_MASTER_ARB -- requirements
Module: wb_master_arb

---
 rtl/wb_arb_pkg.sv | 35 +++
 rtl/wb_master_arb_if.sv | 44 ++++
 rtl/wb_arb_rr2.sv | 32 +++
 rtl/wb_master_arb.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-requester Wishbone classic master arbiter:
// FSM state encodings, the timeout completion data word, the default ack wait
// limit, and a helper that turns a requester beat into the latched bus request.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        DONE = 2'b10
    } arb_state_e;

    localparam logic [31:0] TIMEOUT_DATA       = 32'hDEAD_BEEF;
    localparam int          DEF_TIMEOUT_CYCLES = 255;

    // Everything the Wishbone side holds for the length of one cycle.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } wb_req_t;

    // A zero strobe is a read, and a read selects all four byte lanes.
    function automatic wb_req_t make_req(input logic [31:0] adr,
                                         input logic [31:0] dat,
                                         input logic [3:0]  wstrb);
        wb_req_t r;
        r.adr = adr;
        r.dat = dat;
        r.we  = |wstrb;
        r.sel = r.we ? wstrb : 4'hF;
        return r;
    endfunction

endpackage

// File: rtl/wb_master_arb_if.sv
// Requester handshakes plus the Wishbone classic master bus of wb_master_arb.
// The master modport is the arbiter's view; slave is the surrounding system.
interface wb_master_arb_if;

    logic        m0_valid;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_ready;
    logic [31:0] m0_rdata;

    logic        m1_valid;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_ready;
    logic [31:0] m1_rdata;

    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_stb_o;
    logic        wbm_cyc_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  wbm_dat_i, wbm_ack_i,
        output m0_ready, m0_rdata, m1_ready, m1_rdata,
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
    );

    modport slave (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output wbm_dat_i, wbm_ack_i,
        input  m0_ready, m0_rdata, m1_ready, m1_rdata,
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
    );

endinterface

// File: rtl/wb_arb_rr2.sv
// Two-input round-robin grant. gnt_o is the winning index for the current
// request pattern; the pointer remembers who was served last and only moves
// when the arbiter actually accepts a request (take_i).
module wb_arb_rr2 (
    input  logic       clock_main,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       gnt_o
);

    logic last_q, last_d;

    // Contention goes to whoever did not win last time; otherwise the lone requester.
    always_comb begin
        if (req_i[0] && req_i[1]) gnt_o = ~last_q;
        else                      gnt_o = req_i[1];
    end

    // Pointer follows the winner of an accepted arbitration.
    always_comb begin
        last_d = last_q;
        if (take_i) last_d = gnt_o;
    end

    // Reset state "m1 served last" so the first contention favours m0.
    always_ff @(posedge clock_main or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/wb_master_arb.sv
// Two-requester Wishbone classic master arbiter.
// IDLE arbitrates and latches the winning request, BUS holds stb/cyc until
// ack, DONE is a one-cycle gap while the granted requester sees its ready
// pulse. All Wishbone and requester outputs come straight from flops.
// Optional: define WB_ARB_TIMEOUT_EN to abort a BUS cycle after
// TIMEOUT_CYCLES cycles without ack (rdata DEAD_BEEF, sticky timeout_err).
module wb_master_arb
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clock_main,
    input  logic             rst_n,
    wb_master_arb_if.master  bus,
    output logic             grant,
    output logic             timeout_err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    arb_state_e  state_q;
    wb_req_t     req_q, req_d;
    logic        stb_q, cyc_q, grant_q;
    logic [1:0]  rdy_q;
    logic [31:0] rd0_q, rd1_q;

    logic        arb_gnt, arb_take;
    logic        to_hit, cpl;
    logic [31:0] cpl_data;

    assign arb_take = (state_q == IDLE) && (bus.m0_valid || bus.m1_valid);

    wb_arb_rr2 u_rr (
        .clock_main (clock_main),
        .rst_n      (rst_n),
        .req_i      ({bus.m1_valid, bus.m0_valid}),
        .take_i     (arb_take),
        .gnt_o      (arb_gnt)
    );

    // Request the winner would place on the bus.
    always_comb begin
        req_d = make_req(bus.m0_addr, bus.m0_wdata, bus.m0_wstrb);
        if (arb_gnt) req_d = make_req(bus.m1_addr, bus.m1_wdata, bus.m1_wstrb);
    end

    // A BUS cycle ends on ack or on timeout; ack wins when both land together.
    always_comb begin
        cpl      = (state_q == BUS) && (bus.wbm_ack_i || to_hit);
        cpl_data = bus.wbm_ack_i ? bus.wbm_dat_i : TIMEOUT_DATA;
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic        terr_q;

    assign to_hit      = (state_q == BUS) && !bus.wbm_ack_i && (cnt_q == TO_LAST);
    assign timeout_err = terr_q;

    // Count cycles spent waiting in BUS; zero whenever not waiting.
    always_ff @(posedge clock_main or negedge rst_n) begin
        if (!rst_n)                        cnt_q <= '0;
        else if (state_q == BUS && !cpl)   cnt_q <= cnt_q + 16'd1;
        else                               cnt_q <= '0;
    end

    // Sticky timeout flag, only reset clears it.
    always_ff @(posedge clock_main or negedge rst_n) begin
        if (!rst_n)      terr_q <= 1'b0;
        else if (to_hit) terr_q <= 1'b1;
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Main FSM with registered bus and requester outputs.
    always_ff @(posedge clock_main or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            grant_q <= 1'b0;
            rdy_q   <= 2'b00;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            // Ready and rdata are single-cycle; default them away every cycle.
            rdy_q <= 2'b00;
            rd0_q <= '0;
            rd1_q <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_take) begin
                        req_q   <= req_d;
                        grant_q <= arb_gnt;
                        stb_q   <= 1'b1;
                        cyc_q   <= 1'b1;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    if (cpl) begin
                        stb_q    <= 1'b0;
                        cyc_q    <= 1'b0;
                        req_q.we <= 1'b0;
                        if (grant_q) begin
                            rdy_q[1] <= 1'b1;
                            rd1_q    <= cpl_data;
                        end else begin
                            rdy_q[0] <= 1'b1;
                            rd0_q    <= cpl_data;
                        end
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wbm_adr_o = req_q.adr;
    assign bus.wbm_dat_o = req_q.dat;
    assign bus.wbm_sel_o = req_q.sel;
    assign bus.wbm_we_o  = req_q.we;
    assign bus.wbm_stb_o = stb_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.m0_ready  = rdy_q[0];
    assign bus.m1_ready  = rdy_q[1];
    assign bus.m0_rdata  = rd0_q;
    assign bus.m1_rdata  = rd1_q;
    assign grant         = grant_q;

endmodule
